// File: rtl/led_hold_arbiter.sv
// Shares one long-press hold timer among N buttons; each completed hold toggles that button's LED once.
// Optional `LED_HOLD_CONFLICT_BLOCK_EN: two or more buttons pressed at once block or abort any grant.
module led_hold_arbiter #(
  parameter int unsigned N           = 2,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned HOLD_CYCLES = 33554432,
  parameter logic [N-1:0] LED_INIT   = '1,
  localparam int unsigned IW         = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  btn,
  output logic [N-1:0]  led,
  output logic [N-1:0]  toggle_pulse,
  output logic          grant_vld,
  output logic [IW-1:0] grant_idx
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_n;
  logic [N-1:0]   sync1, bs;
  logic [N-1:0]   lock, lock_n;
  logic [N-1:0]   led_n, pulse_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [IW-1:0]  g, g_n, g_inc;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic           pick_vld;
  logic [IW-1:0]  pick, cand;
  logic           conflict;
  logic           grant_vld_n;
  logic [IW-1:0]  grant_idx_n;

  // Exclusive-press detection
  always_comb begin
`ifdef LED_HOLD_CONFLICT_BLOCK_EN
    conflict = ($countones(bs) > 1);
`else
    conflict = 1'b0;
`endif
  end

  // Round-robin search for the first eligible channel starting at ptr
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!pick_vld && bs[cand] && !lock[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  assign g_inc = (g == IW'(N - 1)) ? '0 : g + IW'(1);

  // Next-state and datapath
  always_comb begin
    state_n = state;
    g_n     = g;
    cnt_n   = cnt;
    ptr_n   = ptr;
    led_n   = led;
    pulse_n = '0;
    lock_n  = lock & bs;
    case (state)
      IDLE: begin
        if (pick_vld && !conflict) begin
          state_n = HOLD;
          g_n     = pick;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (!bs[g] || conflict) begin
          state_n = IDLE;
          cnt_n   = '0;
          ptr_n   = g_inc;
        end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          led_n[g]   = ~led[g];
          pulse_n[g] = 1'b1;
          lock_n[g]  = 1'b1;
          state_n    = IDLE;
          cnt_n      = '0;
          ptr_n      = g_inc;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    grant_vld_n = (state_n == HOLD);
    grant_idx_n = (state_n == HOLD) ? g_n : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync1        <= '0;
      bs           <= '0;
      lock         <= '0;
      ptr          <= '0;
      g            <= '0;
      cnt          <= '0;
      led          <= LED_INIT;
      toggle_pulse <= '0;
      grant_vld    <= 1'b0;
      grant_idx    <= '0;
    end else begin
      state        <= state_n;
      sync1        <= btn;
      bs           <= sync1;
      lock         <= lock_n;
      ptr          <= ptr_n;
      g            <= g_n;
      cnt          <= cnt_n;
      led          <= led_n;
      toggle_pulse <= pulse_n;
      grant_vld    <= grant_vld_n;
      grant_idx    <= grant_idx_n;
    end
  end

endmodule

// File: tb/tb_led_hold_arbiter.sv
// Randomized and directed bench for led_hold_arbiter (N=2, HOLD_CYCLES=4) against a behavioural model.
module tb_led_hold_arbiter;
  localparam int unsigned N = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] led, toggle_pulse;
  logic       grant_vld;
  logic [0:0] grant_idx;

  int errors = 0;
  int checks = 0;
  int ngv = 0;
  int npulse = 0;

  // Model: per-channel press history and a single owner with an elapsed-hold count
  logic [1:0] m_s1, m_s2, m_lock, m_led, m_pulse;
  int m_owner, m_held, m_ptr;

  led_hold_arbiter #(.N(N), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD), .LED_INIT(2'b11)) dut (
    .clk(clk), .rst(rst), .btn(btn), .led(led), .toggle_pulse(toggle_pulse),
    .grant_vld(grant_vld), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [1:0] pressed, nlock;
    logic both;
    int c;
    m_pulse = 2'b00;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_lock = 0; m_led = 2'b11;
      m_owner = -1; m_held = 0; m_ptr = 0;
      return;
    end
    pressed = m_s2;
`ifdef LED_HOLD_CONFLICT_BLOCK_EN
    both = (pressed == 2'b11);
`else
    both = 1'b0;
`endif
    nlock = m_lock & pressed;
    if (m_owner < 0) begin
      if (!both) begin
        for (int k = 0; k < 2; k++) begin
          c = (m_ptr + k) % 2;
          if (m_owner < 0 && pressed[c[0:0]] && !m_lock[c[0:0]]) begin
            m_owner = c;
            m_held = 0;
          end
        end
      end
    end else if (!pressed[m_owner[0:0]] || both) begin
      m_ptr = (m_owner + 1) % 2;
      m_owner = -1;
    end else if (m_held == HOLD - 1) begin
      m_led[m_owner[0:0]] = ~m_led[m_owner[0:0]];
      m_pulse[m_owner[0:0]] = 1'b1;
      nlock[m_owner[0:0]] = 1'b1;
      m_ptr = (m_owner + 1) % 2;
      m_owner = -1;
    end else begin
      m_held++;
    end
    m_lock = nlock;
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led", 32'(led), 32'(m_led));
    check("pulse", 32'(toggle_pulse), 32'(m_pulse));
    check("gvld", 32'(grant_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("gidx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    if (grant_vld) ngv++;
    if (toggle_pulse != 2'b00) npulse++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_gv();
    int n = 0;
    while (!grant_vld && n < 10) begin
      tick();
      n++;
    end
    check("wait_gvld", 32'(grant_vld), 32'd1);
  endtask

  initial begin
    int dur;
    m_owner = -1; m_held = 0; m_ptr = 0;
    m_s1 = 0; m_s2 = 0; m_lock = 0; m_led = 2'b11; m_pulse = 0;
    rst = 1'b1;
    btn = 2'b00;
    ticks(3);
    rst = 1'b0;

    // Reset then idle
    ngv = 0; npulse = 0;
    ticks(10);
    check("idle_led", 32'(led), 32'h3);
    check("idle_gv_cycles", 32'(ngv), 32'd0);
    check("idle_pulses", 32'(npulse), 32'd0);

    // Single long hold: exactly one toggle, grant lasts HOLD cycles
    ngv = 0; npulse = 0;
    btn = 2'b01;
    ticks(20);
    check("hold_gv_cycles", 32'(ngv), 32'd4);
    check("hold_pulses", 32'(npulse), 32'd1);
    check("hold_led", 32'(led), 32'h2);
    btn = 2'b00;
    ticks(5);
    btn = 2'b01;
    ticks(20);
    check("repress_led", 32'(led), 32'h3);

    // Early release aborts; ptr moves past channel 0
    btn = 2'b00;
    ticks(5);
    npulse = 0;
    btn = 2'b01;
    wait_gv();
    btn = 2'b00;
    ticks(6);
    check("abort_led", 32'(led), 32'h3);
    check("abort_pulses", 32'(npulse), 32'd0);
`ifndef LED_HOLD_CONFLICT_BLOCK_EN
    btn = 2'b11;
    wait_gv();
    check("abort_next_idx", 32'(grant_idx), 32'd1);
`endif
    btn = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Simultaneous presses
    npulse = 0; ngv = 0;
    btn = 2'b11;
    ticks(30);
`ifdef LED_HOLD_CONFLICT_BLOCK_EN
    check("both_led", 32'(led), 32'h3);
    check("both_pulses", 32'(npulse), 32'd0);
    check("both_gv_cycles", 32'(ngv), 32'd0);
`else
    check("both_led", 32'(led), 32'h0);
    check("both_pulses", 32'(npulse), 32'd2);
`endif
    btn = 2'b00;
    ticks(5);

    // Reset during the third HOLD cycle
    npulse = 0;
    btn = 2'b01;
    wait_gv();
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    btn = 2'b00;
    check("rst_hold_gvld", 32'(grant_vld), 32'd0);
    check("rst_hold_led", 32'(led), 32'h3);
    check("rst_hold_pulses", 32'(npulse), 32'd0);
    ticks(3);

`ifdef LED_HOLD_CONFLICT_BLOCK_EN
    // Second press mid-hold aborts
    npulse = 0;
    btn = 2'b01;
    wait_gv();
    btn = 2'b11;
    ticks(10);
    check("conflict_abort_pulses", 32'(npulse), 32'd0);
    btn = 2'b00;
    ticks(4);
`endif

    // Randomized segments with occasional reset
    for (int s = 0; s < 400; s++) begin
      btn = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      dur = $urandom_range(1, 12);
      tick();
      rst = 1'b0;
      ticks(dur - 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
